// File: rtl/spi_device_tx_arbiter.sv
// Round-robin arbiter sharing the SPI device TX FIFO write port between
// NUM_REQ requesters. Bursts are granted atomically until req_last or
// MAX_BURST beats; one registered valid/ready stage drives the FIFO.
//
// Ports:
//   clk, rst     write-side clock, synchronous active-high reset
//   req_data     requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid    per-requester beat valid
//   req_last     per-requester end-of-burst marker
//   req_ready    per-requester beat accepted (combinational)
//   fifo_data    FIFO write data (registered)
//   fifo_valid   FIFO write valid (registered)
//   fifo_ready   FIFO write ready
//   grant_id     current/last granted requester
//   busy         arbiter in a grant or output register holding a beat
module spi_device_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic                            fifo_valid,
  input  logic                            fifo_ready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [CW-1:0]         beat_cnt;
  logic [GW-1:0]         rr_ptr;

  logic                  load_ok;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  end_burst;
  logic                  any_valid;
  logic                  found;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         grant_inc;
  logic [2*NUM_REQ-1:0]  rot;
  logic                  stay_grant;
  logic                  next_valid;

  // Output register can take a new beat when empty or draining this cycle.
  assign load_ok   = !fifo_valid || fifo_ready;
  assign any_valid = |req_valid;

  // Mux the granted requester's beat.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready goes only to the granted requester, and only when the stage can load.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready[i] = (state == GRANT) && (grant_id == GW'(i)) && load_ok;
    end
  end

  // First valid requester at or after rr_ptr, cyclically: rotate then scan.
  always_comb begin
    rot   = {req_valid, req_valid} >> rr_ptr;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pick  = GW'((int'(rr_ptr) + k) % int'(NUM_REQ));
      end
    end
  end

  assign accept     = (state == GRANT) && sel_valid && load_ok;
  assign end_burst  = accept && (sel_last || (beat_cnt == CW'(MAX_BURST - 1)));
  assign grant_inc  = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
  assign stay_grant = (state == IDLE) ? any_valid : !end_burst;
  assign next_valid = accept || (fifo_valid && !fifo_ready);

  // Arbitration FSM and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      rr_ptr     <= '0;
      fifo_valid <= 1'b0;
      fifo_data  <= '0;
      busy       <= 1'b0;
    end else begin
      if (accept) begin
        fifo_valid <= 1'b1;
        fifo_data  <= sel_data;
      end else if (fifo_ready) begin
        fifo_valid <= 1'b0;
      end

      busy <= stay_grant || next_valid;

      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A dropped req_valid just stalls here; only an accepted beat can end the burst.
          if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (end_burst) begin
              rr_ptr <= grant_inc;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_device_tx_arbiter.sv
// Self-checking bench for spi_device_tx_arbiter: arbitration table, directed
// burst/back-pressure/reset sequences and randomized streams against a
// queue-based round-robin burst model.
module tb_spi_device_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   fifo_data;
  logic            fifo_valid;
  logic            fifo_ready;
  logic [GW-1:0]   grant_id;
  logic            busy;

  spi_device_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .fifo_data(fifo_data),
    .fifo_valid(fifo_valid), .fifo_ready(fifo_ready), .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] valid;
    int            exp_grant;
  } vec_t;

  vec_t          vecs[12];
  int            n_checks = 0;
  int            n_err = 0;
  logic [DW-1:0] q_data[NR][$];
  bit            q_last[NR][$];
  logic [DW-1:0] exp_q[$];
  int            out_ids[$];
  int            xfer_cyc[$];
  int            m_ptr;
  logic [7:0]    seq = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      q_data[r].push_back({8'(r), seq, 16'(k)});
      q_last[r].push_back(k == len - 1);
    end
    seq++;
  endtask

  // Reference: round-robin over non-empty requesters, each grant takes beats
  // until a last beat or MB beats, pointer moves past the granted requester.
  task automatic build_expected();
    int hi[NR];
    int ptr;
    int g;
    int n;
    bit lst;
    ptr = m_ptr;
    for (int i = 0; i < NR; i++) hi[i] = 0;
    exp_q.delete();
    while (1) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int c = (ptr + k) % NR;
        if (g < 0 && hi[c] < q_data[c].size()) g = c;
      end
      if (g < 0) break;
      n = 0;
      lst = 0;
      while (!lst && n < MB && hi[g] < q_data[g].size()) begin
        exp_q.push_back(q_data[g][hi[g]]);
        lst = q_last[g][hi[g]];
        hi[g]++;
        n++;
      end
      ptr = (g + 1) % NR;
    end
    m_ptr = ptr;
  endtask

  task automatic drive_heads();
    for (int i = 0; i < NR; i++) begin
      if (q_data[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = q_last[i][0];
        req_data[i*DW +: DW] = q_data[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // mode 0: fifo_ready=1; mode 1: random ready; mode 2: ready low on cycles 4..8.
  task automatic run_stream(input int mode, input int maxc);
    int cyc;
    bit have_hold;
    logic [DW-1:0] hold_d;
    cyc = 0;
    have_hold = 0;
    hold_d = '0;
    xfer_cyc.delete();
    out_ids.delete();
    build_expected();
    while (cyc < maxc && exp_q.size() > 0) begin
      @(negedge clk);
      drive_heads();
      if (mode == 0) fifo_ready = 1'b1;
      else if (mode == 1) fifo_ready = ($urandom_range(0, 9) < 7);
      else fifo_ready = !(cyc >= 4 && cyc < 9);
      #1;
      if (have_hold) begin
        chk("hold_valid", fifo_valid, 1);
        chk("hold_data", fifo_data, hold_d);
      end
      if (fifo_valid && !fifo_ready) chk("stall_ready", req_ready, 0);
      if (fifo_valid) chk("busy_valid", busy, 1);
      if (fifo_valid && fifo_ready) begin
        chk("beat", fifo_data, exp_q.pop_front());
        out_ids.push_back(int'(fifo_data[31:24]));
        xfer_cyc.push_back(cyc);
      end
      have_hold = fifo_valid && !fifo_ready;
      hold_d = fifo_data;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          void'(q_data[i].pop_front());
          void'(q_last[i].pop_front());
        end
      end
      cyc++;
    end
    chk("stream_left", exp_q.size(), 0);
    @(negedge clk);
    drive_heads();
    fifo_ready = 1'b1;
    #1;
    chk("drain_valid", fifo_valid, 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    logic [DW-1:0] ed;

    // rr_ptr is 1 entering the table (after the req0 burst).
    vecs[0]  = '{4'b1111, 1};
    vecs[1]  = '{4'b1111, 2};
    vecs[2]  = '{4'b1111, 3};
    vecs[3]  = '{4'b1111, 0};
    vecs[4]  = '{4'b1111, 1};
    vecs[5]  = '{4'b0001, 0};
    vecs[6]  = '{4'b1000, 3};
    vecs[7]  = '{4'b0110, 1};
    vecs[8]  = '{4'b0011, 0};
    vecs[9]  = '{4'b1010, 1};
    vecs[10] = '{4'b1010, 3};
    vecs[11] = '{4'b0010, 1};

    rst = 1'b1;
    req_data = '0;
    req_valid = '0;
    req_last = '0;
    fifo_ready = 1'b0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fifo_valid", fifo_valid, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Req0 sends A,B,C: beats on cycles 2,3,4 after valid appears.
    push_burst(0, 3);
    run_stream(0, 50);
    chk("t1_count", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      chk("t1_first_cycle", xfer_cyc[0], 2);
      chk("t1_last_cycle", xfer_cyc[2], 4);
    end

    // Single-beat arbitration table.
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      fifo_ready = 1'b1;
      req_valid = vecs[t].valid;
      req_last = '1;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {8'(i), 8'hA5, 16'(t)};
      #1;
      w = 0;
      while (req_ready == 0 && w < 6) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk("tbl_grant_id", grant_id, vecs[t].exp_grant);
      chk("tbl_req_ready", req_ready, 4'b0001 << vecs[t].exp_grant);
      @(negedge clk);
      req_valid = '0;
      #1;
      ed = {8'(vecs[t].exp_grant), 8'hA5, 16'(t)};
      chk("tbl_fifo_valid", fifo_valid, 1);
      chk("tbl_fifo_data", fifo_data, ed);
      @(negedge clk);
    end
    m_ptr = (vecs[11].exp_grant + 1) % NR;

    // Req2 20 beats (last only on beat 20) against a single req1 beat.
    push_burst(2, 20);
    push_burst(1, 1);
    run_stream(0, 200);
    chk("t3_count", out_ids.size(), 21);
    if (out_ids.size() == 21) begin
      chk("t3_id7", out_ids[7], 2);
      chk("t3_id8", out_ids[8], 1);
      chk("t3_id9", out_ids[9], 2);
    end

    // Five-cycle FIFO stall mid-burst.
    push_burst(0, 6);
    run_stream(2, 200);

    // Reset with a beat held in the output register.
    @(negedge clk);
    fifo_ready = 1'b0;
    req_valid = 4'b1000;
    req_last = '0;
    req_data = '0;
    req_data[3*DW +: DW] = 32'hDEAD_0003;
    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (!fifo_valid && w < 8);
    chk("t5_loaded", fifo_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_fifo_valid", fifo_valid, 0);
    chk("t5_fifo_data", fifo_data, 0);
    chk("t5_req_ready", req_ready, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_busy", busy, 0);
    rst = 1'b0;
    req_valid = '0;
    m_ptr = 0;
    for (int i = 0; i < NR; i++) push_burst(i, 1);
    run_stream(0, 100);
    if (out_ids.size() > 0) chk("t5_first_req0", out_ids[0], 0);
    else chk("t5_first_req0", out_ids.size(), 1);

    // Randomized bursts with random FIFO back-pressure.
    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < NR; r++) begin
        int nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) push_burst(r, $urandom_range(1, 12));
      end
      run_stream(1, 4000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
